// File: rtl/wb_initiator_pkg.sv
// -----------------------------------------------------------------------------
// wb_initiator_pkg
// Shared definitions for the Wishbone classic single-transaction initiator:
// the controller state encoding and the default strobe timeout.
// -----------------------------------------------------------------------------
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;

endpackage : wb_initiator_pkg

// File: rtl/wb_timeout_ctr.sv
// -----------------------------------------------------------------------------
// wb_timeout_ctr
// 8-bit wait counter for the bus phase. Counts bus cycles without ack and
// flags the cycle in which the strobe has been high for LIMIT cycles.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   clear_i    zero the count (asserted on bus-phase entry)
//   enable_i   increment the count (bus cycle without ack)
//   expired_o  current bus cycle is the last one permitted
// -----------------------------------------------------------------------------
module wb_timeout_ctr
    import wb_initiator_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of completed ack-less cycles, so the LIMIT-th
    // strobe cycle is the one in which count_q == LIMIT-1.
    assign expired_o = (count_q == 8'(LIMIT - 1));

endmodule : wb_timeout_ctr

// File: rtl/wb_initiator.sv
// -----------------------------------------------------------------------------
// wb_initiator
// Converts a valid/ready request into a single Wishbone classic master cycle
// and returns the result on a valid/ready response channel. One transaction
// outstanding at a time; a cycle with no ack for TIMEOUT_CYCLES strobe cycles
// is abandoned and reported with rsp_err.
//
// Ports:
//   wb_clk_i, wb_rst_i              clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_we/adr/dat/sel              request payload
//   rsp_valid/rsp_ready             response handshake
//   rsp_dat, rsp_err                read data (0 for writes), timeout flag
//   wbm_cyc_o..wbm_dat_o            Wishbone master outputs (registered)
//   wbm_dat_i, wbm_ack_i            Wishbone slave responses
//   busy                            controller not idle
// -----------------------------------------------------------------------------
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter bit          RSP_ON_WRITE   = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    input  logic [3:0]  req_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy
);

    wb_state_e   state_q, state_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic        ctr_clear, ctr_en, ctr_expired;

    wb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clear_i   (ctr_clear),
        .enable_i  (ctr_en),
        .expired_o (ctr_expired)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        ctr_clear = 1'b0;
        ctr_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    sel_d     = req_sel;
                    adr_d     = req_adr;
                    dat_d     = req_dat;
                    ctr_clear = 1'b1;
                    state_d   = ST_BUS;
                end
            end
            ST_BUS: begin
                // ack is tested before expiry so an ack in the last permitted
                // cycle completes normally.
                if (wbm_ack_i) begin
                    rsp_dat_d = we_q ? '0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = (we_q && !RSP_ON_WRITE) ? ST_IDLE : ST_RESP;
                end else begin
                    ctr_en = 1'b1;
                    if (ctr_expired) begin
                        rsp_dat_d = '0;
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = (state_q == ST_BUS);
    assign wbm_stb_o = (state_q == ST_BUS);
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule : wb_initiator

// File: tb/tb_wb_initiator.sv
// -----------------------------------------------------------------------------
// tb_wb_initiator
// Directed bench for wb_initiator with TIMEOUT_CYCLES=8. A second instance
// with RSP_ON_WRITE=0 shares all inputs and is checked for silent writes.
// -----------------------------------------------------------------------------
module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, rsp_ready, wbm_ack_i;
    logic [31:0] req_adr, req_dat, wbm_dat_i;
    logic [3:0]  req_sel;

    logic        req_ready, rsp_valid, rsp_err, busy;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] rsp_dat, wbm_adr_o, wbm_dat_o;

    logic        d0_req_ready, d0_rsp_valid, d0_rsp_err, d0_busy;
    logic        d0_cyc, d0_stb, d0_we;
    logic [3:0]  d0_sel;
    logic [31:0] d0_rsp_dat, d0_adr, d0_dat;

    always #5 clk = ~clk;

    wb_initiator #(.TIMEOUT_CYCLES(8), .RSP_ON_WRITE(1'b1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
    );

    wb_initiator #(.TIMEOUT_CYCLES(8), .RSP_ON_WRITE(1'b0)) dut_silent (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid(req_valid), .req_ready(d0_req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .rsp_valid(d0_rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(d0_rsp_dat), .rsp_err(d0_rsp_err),
        .wbm_cyc_o(d0_cyc), .wbm_stb_o(d0_stb), .wbm_we_o(d0_we),
        .wbm_sel_o(d0_sel), .wbm_adr_o(d0_adr), .wbm_dat_o(d0_dat),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(d0_busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int unsigned ack_at;    // 0-based strobe cycle carrying ack; >=8 means never
        logic [31:0] ack_data;
        int unsigned exp_stb;
        logic [31:0] exp_rsp;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one request, plays the slave, and returns in the first cycle
    // after the strobe drops.
    task automatic issue(input vec_t v, output int unsigned stb_cnt, output bit stable_ok);
        req_valid = 1'b1;
        req_we    = v.we;
        req_adr   = v.adr;
        req_dat   = v.dat;
        req_sel   = v.sel;
        tick();
        req_valid = 1'b0;
        req_we    = ~v.we;
        req_adr   = 32'h0;
        req_dat   = 32'h0;
        req_sel   = 4'h0;
        stb_cnt   = 0;
        stable_ok = 1'b1;
        while (wbm_stb_o === 1'b1 && stb_cnt < 300) begin
            if (wbm_cyc_o !== 1'b1 || wbm_we_o !== v.we || wbm_adr_o !== v.adr ||
                wbm_dat_o !== v.dat || wbm_sel_o !== v.sel)
                stable_ok = 1'b0;
            wbm_ack_i = (stb_cnt == v.ack_at);
            wbm_dat_i = wbm_ack_i ? v.ack_data : (32'h5A5A_0000 ^ stb_cnt);
            stb_cnt++;
            tick();
        end
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned cnt;
        bit          ok;
        bit          seen;
        vec_t        v;

        vecs[0] = '{we:1'b0, adr:32'h3000_0004, dat:32'h0, sel:4'hF, ack_at:0,
                    ack_data:32'hDEAD_BEEF, exp_stb:1, exp_rsp:32'hDEAD_BEEF, exp_err:1'b0};
        vecs[1] = '{we:1'b1, adr:32'h3000_0000, dat:32'h0000_00A5, sel:4'b0001, ack_at:3,
                    ack_data:32'hFFFF_FFFF, exp_stb:4, exp_rsp:32'h0, exp_err:1'b0};
        vecs[2] = '{we:1'b0, adr:32'h3000_0008, dat:32'h0, sel:4'hF, ack_at:1000,
                    ack_data:32'h0, exp_stb:8, exp_rsp:32'h0, exp_err:1'b1};
        vecs[3] = '{we:1'b0, adr:32'h3000_000C, dat:32'h0, sel:4'hF, ack_at:7,
                    ack_data:32'h1234_5678, exp_stb:8, exp_rsp:32'h1234_5678, exp_err:1'b0};
        vecs[4] = '{we:1'b1, adr:32'h3000_0040, dat:32'hCAFE_0001, sel:4'b1100, ack_at:1000,
                    ack_data:32'h0, exp_stb:8, exp_rsp:32'h0, exp_err:1'b1};
        vecs[5] = '{we:1'b0, adr:32'h3000_0080, dat:32'h0, sel:4'b0110, ack_at:6,
                    ack_data:32'hA5A5_5A5A, exp_stb:7, exp_rsp:32'hA5A5_5A5A, exp_err:1'b0};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0;
        req_sel = '0; rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
        tick();
        tick();
        chk("rst_cyc", wbm_cyc_o, 0);   chk("rst_stb", wbm_stb_o, 0);
        chk("rst_we", wbm_we_o, 0);     chk("rst_sel", wbm_sel_o, 0);
        chk("rst_adr", wbm_adr_o, 0);   chk("rst_dat", wbm_dat_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_dat", rsp_dat, 0);
        chk("rst_rsp_err", rsp_err, 0); chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            chk("idle_req_ready", req_ready, 1);
            issue(vecs[i], cnt, ok);
            chk("stb_cycles", 32'(cnt), 32'(vecs[i].exp_stb));
            chk("wbm_stable", 32'(ok), 1);
            chk("rsp_valid", rsp_valid, 1);
            chk("req_ready_in_resp", req_ready, 0);
            chk("rsp_dat", rsp_dat, vecs[i].exp_rsp);
            chk("rsp_err", rsp_err, 32'(vecs[i].exp_err));
            chk("silent_write_rsp_valid", d0_rsp_valid, 32'(!(vecs[i].we && !vecs[i].exp_err)));
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk("rsp_valid_after_hs", rsp_valid, 0);
            chk("busy_after_hs", busy, 0);
        end

        // Response back-pressure with a competing request offered in RESP.
        v = '{we:1'b0, adr:32'h3000_0010, dat:32'h0, sel:4'hF, ack_at:0,
              ack_data:32'hCAFE_F00D, exp_stb:1, exp_rsp:32'hCAFE_F00D, exp_err:1'b0};
        issue(v, cnt, ok);
        chk("bp_stb_cycles", 32'(cnt), 1);
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h1111_1111;
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_dat", rsp_dat, 32'hCAFE_F00D);
            chk("bp_req_ready", req_ready, 0);
            tick();
        end
        chk("bp_adr_not_reloaded", wbm_adr_o, 32'h3000_0010);
        chk("bp_no_stb", wbm_stb_o, 0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_rsp_valid_after_hs", rsp_valid, 0);

        // Spurious ack while idle.
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hBAD0_BAD0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (busy !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0) seen = 1'b1;
        end
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        chk("idle_ack_ignored", 32'(seen), 0);
        chk("idle_ack_rsp_dat", rsp_dat, 32'hCAFE_F00D);

        // Reset in the second bus cycle.
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0020; req_sel = 4'hF;
        tick();
        req_valid = 1'b0;
        chk("mid_bus_stb1", wbm_stb_o, 1);
        tick();
        chk("mid_bus_stb2", wbm_stb_o, 1);
        rst = 1'b1;
        tick();
        chk("mid_bus_rst_stb", wbm_stb_o, 0);
        chk("mid_bus_rst_cyc", wbm_cyc_o, 0);
        chk("mid_bus_rst_busy", busy, 0);
        chk("mid_bus_rst_adr", wbm_adr_o, 0);
        chk("mid_bus_rst_silent_busy", d0_busy, 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid !== 1'b0 || wbm_stb_o !== 1'b0) seen = 1'b1;
        end
        chk("mid_bus_no_rsp", 32'(seen), 0);
        chk("mid_bus_req_ready", req_ready, 1);

        // Reset while a response is pending.
        v = '{we:1'b0, adr:32'h3000_0030, dat:32'h0, sel:4'hF, ack_at:0,
              ack_data:32'h0000_0077, exp_stb:1, exp_rsp:32'h0000_0077, exp_err:1'b0};
        issue(v, cnt, ok);
        chk("resp_rst_pre_valid", rsp_valid, 1);
        chk("resp_rst_pre_dat", rsp_dat, 32'h0000_0077);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("resp_rst_valid", rsp_valid, 0);
        chk("resp_rst_dat", rsp_dat, 0);
        tick();
        chk("resp_rst_valid_later", rsp_valid, 0);
        chk("resp_rst_req_ready", req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_wb_initiator

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 The block SHALL take parameter TIMEOUT_CYCLES, default 64, meaning the maximum cycles the strobe is held awaiting ack (legal range 2..255).
REQ-002 The block SHALL take parameter RSP_ON_WRITE, default 1, meaning writes also produce a response beat (0 = writes complete silently).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 wb_clk_i  input  1  sole clock, all logic on rising edge.
REQ-005 wb_rst_i  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  request offered; req_ready  output  1  request accepted when both high.
REQ-007 req_we  input  1; req_adr  input  32; req_dat  input  32; req_sel  input  4  request payload.
REQ-008 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-009 rsp_dat  output  32  read data; rsp_err  output  1  transaction timed out.
REQ-010 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each; wbm_sel_o  output  4; wbm_adr_o, wbm_dat_o  output  32  Wishbone classic master outputs.
REQ-011 wbm_dat_i  input  32; wbm_ack_i  input  1  Wishbone slave responses.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block SHALL implement states IDLE, BUS, RESP.
REQ-014 IDLE: req_ready=1, cyc/stb=0; on req_valid the payload SHALL be registered and state SHALL go to BUS.
REQ-015 BUS: cyc=stb=1, we/sel/adr/dat driven from registered payload and held stable for the whole state.
REQ-016 Request accepted at edge N SHALL show cyc/stb high in cycle N+1; no combinational path from req_* to wbm_*.
REQ-017 ack sampled high in BUS SHALL drop cyc/stb at the next edge, capture wbm_dat_i into rsp_dat for reads (0 for writes), clear rsp_err, and go to RESP (or IDLE for a write when RSP_ON_WRITE=0).
REQ-018 A 8-bit wait counter SHALL clear on BUS entry and increment each BUS cycle without ack.
REQ-019 After stb has been high TIMEOUT_CYCLES cycles with no ack, cyc/stb SHALL drop, rsp_dat=0, rsp_err=1, state RESP (timeout always responds, regardless of RSP_ON_WRITE).
REQ-020 ack in the final permitted cycle SHALL win over timeout.
REQ-021 RESP: rsp_valid=1, rsp_dat/rsp_err stable until rsp_ready; on handshake state SHALL go to IDLE; req_ready rises the following cycle (no same-cycle bypass).
REQ-022 Best-case latency: accept at N, ack in N+1, rsp_valid in N+2.
REQ-023 wbm_ack_i outside BUS SHALL be ignored; req_valid outside IDLE SHALL be ignored (ready low).
REQ-024 Only one outstanding transaction; no pipelining or burst.

Reset
REQ-025 wb_rst_i SHALL force IDLE, clear counter, and drive cyc=stb=we=0, sel=0, adr=dat=0, rsp_valid=0, rsp_dat=0, rsp_err=0, busy=0 at the next edge.
REQ-026 Reset mid-BUS SHALL abandon the cycle (cyc/stb low next edge) with no response; reset in RESP SHALL discard the pending response.

Structure
REQ-027 State encoding constants and default TIMEOUT_CYCLES SHALL live in shared package wb_initiator_pkg.
REQ-028 The wait counter SHALL be sub-module wb_timeout_ctr (inputs clear/enable, output expired); everything else in wb_initiator.

Verification
REQ-029 Read 0x3000_0004, slave acks 1 cycle after stb with 0xDEAD_BEEF -> rsp_valid at N+2, rsp_dat=0xDEADBEEF, rsp_err=0.
REQ-030 Write 0x3000_0000 data 0x0000_00A5 sel 4'b0001, ack after 3 cycles -> wbm outputs stable 4 cycles, rsp_dat=0, rsp_err=0.
REQ-031 Read, slave never acks, TIMEOUT_CYCLES=8 -> stb high exactly 8 cycles, rsp_err=1, rsp_dat=0.
REQ-032 TIMEOUT_CYCLES=8, ack in 8th stb cycle -> rsp_err=0, data captured.
REQ-033 rsp_ready held low 5 cycles -> rsp_valid/rsp_dat stable, req_ready low throughout; spurious ack in IDLE has no effect.
REQ-034 wb_rst_i asserted in 2nd BUS cycle -> cyc/stb low next edge, no rsp_valid, req_ready high after reset release.
